// File: rtl/mmio_seg_display.sv
// mmio_seg_display: memory-mapped multiplexed 7-segment display controller
module mmio_seg_display #(
   parameter int          NUM_DIGITS = 4,
   parameter int          SCAN_DIV   = 100000,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0010
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           Address,
   input  logic [31:0]           Write_data,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   output logic [31:0]           Read_data,
   output logic [7:0]            BCDData,
   output logic [NUM_DIGITS-1:0] an
);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(SCAN_DIV);
   localparam int VW = 4 * NUM_DIGITS;
   logic [VW-1:0]         value_q;
   logic                  en;
   logic                  mode;
   logic [7:0]            dp_mask;
   logic [7:0]            blank_mask;
   logic [31:0]           raw0;
   logic [31:0]           raw1;
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [31:0]           offset;
   logic                  hit;
   logic [1:0]            sel;
   logic [2:0]            di;
   logic [31:0]           value_w;
   logic [63:0]           raw_all;
   logic [3:0]            nib;
   logic [7:0]            raw_byte;
   logic                  lit;
   logic [NUM_DIGITS-1:0] an_d;
   logic [7:0]            seg_d;
   logic                  unused;
   function automatic logic [6:0] hexseg(input logic [3:0] n);
      case (n)
         4'h0: hexseg = 7'h40;
         4'h1: hexseg = 7'h79;
         4'h2: hexseg = 7'h24;
         4'h3: hexseg = 7'h30;
         4'h4: hexseg = 7'h19;
         4'h5: hexseg = 7'h12;
         4'h6: hexseg = 7'h02;
         4'h7: hexseg = 7'h78;
         4'h8: hexseg = 7'h00;
         4'h9: hexseg = 7'h10;
         4'hA: hexseg = 7'h08;
         4'hB: hexseg = 7'h03;
         4'hC: hexseg = 7'h46;
         4'hD: hexseg = 7'h21;
         4'hE: hexseg = 7'h06;
         default: hexseg = 7'h0E;
      endcase
   endfunction
   // BASE_ADDR is word-aligned, so the byte lane bits never borrow into the register select
   assign offset  = Address - BASE_ADDR;
   assign hit     = offset[31:4] == 28'h0;
   assign sel     = offset[3:2];
   assign unused  = ^offset[1:0];
   assign di      = 3'(idx);
   assign value_w = 32'(value_q);
   assign raw_all = {raw1, raw0};
   assign nib      = value_w[{di, 2'b00} +: 4];
   assign raw_byte = raw_all[{di, 3'b000} +: 8];
   // Combinational register read; misses and idle cycles return zero
   always_comb begin
      Read_data = 32'h0;
      if (MemRead && hit)
         Read_data = sel == 2'd0 ? value_w :
                     sel == 2'd1 ? {8'h00, blank_mask, dp_mask, 6'h00, mode, en} :
                     sel == 2'd2 ? raw0 : raw1;
   end
   // Register file writes on a bus hit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q    <= '0;
         en         <= 1'b0;
         mode       <= 1'b0;
         dp_mask    <= 8'h00;
         blank_mask <= 8'h00;
         raw0       <= 32'h0;
         raw1       <= 32'h0;
      end else if (MemWrite && hit) begin
         case (sel)
            2'd0: value_q <= Write_data[VW-1:0];
            2'd1: begin
               en         <= Write_data[0];
               mode       <= Write_data[1];
               dp_mask    <= Write_data[15:8];
               blank_mask <= Write_data[23:16];
            end
            2'd2: raw0 <= Write_data;
            default: raw1 <= Write_data;
         endcase
      end
   end
   // Scan timer and digit index; both parked at zero while disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (!en) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CW'(SCAN_DIV - 1)) begin
         cnt <= '0;
         idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
   // Pin values for the current digit
   always_comb begin
      lit   = en && !blank_mask[di];
      an_d  = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg_d = !lit ? 8'hFF : mode ? raw_byte : {~dp_mask[di], hexseg(nib)};
   end
   // Registered board pins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an      <= '1;
         BCDData <= 8'hFF;
      end else begin
         an      <= an_d;
         BCDData <= seg_d;
      end
   end
endmodule

// File: tb/tb_mmio_seg_display.sv
// tb_mmio_seg_display: table-driven and randomized checks against a behavioural model
module tb_mmio_seg_display;
   localparam int          ND   = 4;
   localparam int          SD   = 4;
   localparam logic [31:0] BASE = 32'h4000_0010;
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   Address = 32'h0;
   logic [31:0]   Write_data = 32'h0;
   logic          MemRead = 1'b0;
   logic          MemWrite = 1'b0;
   logic [31:0]   Read_data;
   logic [7:0]    BCDData;
   logic [ND-1:0] an;
   mmio_seg_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
      .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data),
      .BCDData(BCDData), .an(an)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t tbl [13];
   int n_chk = 0;
   int n_fail = 0;
   logic [31:0]   m_value, m_ctrl, m_raw0, m_raw1;
   int            ticks;
   logic [ND-1:0] exp_an;
   logic [7:0]    exp_seg;
   logic [6:0]    hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic int hit_off(input logic [31:0] a);
      logic [31:0] off;
      off = {a[31:2], 2'b00} - BASE;
      return off < 32'd16 ? int'(off) : -1;
   endfunction
   function automatic logic [31:0] m_read(input logic [31:0] a);
      case (hit_off(a))
         0: return m_value;
         4: return m_ctrl;
         8: return m_raw0;
         12: return m_raw1;
         default: return 32'h0;
      endcase
   endfunction
   task automatic m_reset();
      m_value = 0; m_ctrl = 0; m_raw0 = 0; m_raw1 = 0; ticks = 0;
   endtask
   task automatic m_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
      int i;
      logic [63:0] raw;
      i = (ticks / SD) % ND;
      raw = {m_raw1, m_raw0};
      if (!m_ctrl[0] || m_ctrl[16+i]) begin
         exp_an = '1;
         exp_seg = 8'hFF;
      end else begin
         exp_an = ~(ND'(1) << i);
         exp_seg = m_ctrl[1] ? raw[8*i +: 8] : {~m_ctrl[8+i], hex_tab[m_value[4*i +: 4]]};
      end
      ticks = m_ctrl[0] ? ticks + 1 : 0;
      if (w)
         case (hit_off(a))
            0: m_value = d & 32'h0000_FFFF;
            4: m_ctrl = d & 32'h00FF_FF03;
            8: m_raw0 = d;
            12: m_raw1 = d;
            default: ;
         endcase
   endtask
   task automatic step(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
      Address = a; Write_data = d; MemWrite = w; MemRead = r;
      #1;
      chk("read_data", Read_data, exp_rd);
      @(posedge clk);
      m_edge(w, a, d);
      @(negedge clk);
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(BCDData), 32'(exp_seg));
      MemWrite = 1'b0; MemRead = 1'b0;
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, BASE, 32'h0, 32'h0);
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b1, 1'b0, a, d, 32'h0);
   endtask
   initial begin
      int seen_d;
      logic got;
      logic [31:0] a, d;
      logic r, w;
      m_reset();
      tbl[0]  = '{1'b1, 1'b0, BASE,          32'h0000_1234, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, BASE,          32'h0,         32'h0000_1234};
      tbl[2]  = '{1'b1, 1'b0, BASE + 4,      32'h0000_0001, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, BASE + 4,      32'h0,         32'h0000_0001};
      tbl[4]  = '{1'b0, 1'b1, BASE + 32'h10, 32'h0,         32'h0};
      tbl[5]  = '{1'b1, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0};
      tbl[6]  = '{1'b0, 1'b1, BASE,          32'h0,         32'h0000_1234};
      tbl[7]  = '{1'b0, 1'b1, BASE + 6,      32'h0,         32'h0000_0001};
      tbl[8]  = '{1'b1, 1'b1, BASE,          32'hFFFF_ABCD, 32'h0000_1234};
      tbl[9]  = '{1'b0, 1'b1, BASE,          32'h0,         32'h0000_ABCD};
      tbl[10] = '{1'b1, 1'b0, BASE,          32'h0000_1234, 32'h0};
      tbl[11] = '{1'b0, 1'b1, BASE - 4,      32'h0,         32'h0};
      tbl[12] = '{1'b0, 1'b0, BASE,          32'h0,         32'h0};
      // reset held: pins parked
      Address = BASE; MemRead = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_an", 32'(an), 32'hF);
         chk("rst_seg", 32'(BCDData), 32'hFF);
         chk("rst_rd", Read_data, 32'h0);
      end
      MemRead = 1'b0;
      reset = 1'b1;
      for (int k = 0; k < 20; k++) step(1'b0, 1'b1, BASE + 32'(4 * (k % 4)), 32'h0, 32'h0);
      // register access table
      for (int k = 0; k < 13; k++) step(tbl[k].w, tbl[k].r, tbl[k].a, tbl[k].d, tbl[k].exp_rd);
      idle(24);
      // blank digit 1, decimal points on digits 0 and 1
      wr(BASE + 4, 32'h0002_0301);
      seen_d = 0; got = 1'b0;
      for (int k = 0; k < 24; k++) begin
         idle(1);
         if (an == 4'hD) seen_d++;
         if (an == 4'hE && !got) begin
            got = 1'b1;
            chk("dp_digit0", 32'(BCDData), 32'h19);
         end
      end
      chk("blank_never_d", 32'(seen_d), 32'h0);
      chk("digit0_seen", 32'(got), 32'h1);
      // raw segment mode
      wr(BASE + 8, 32'h7F3F_5A01);
      wr(BASE + 4, 32'h0000_0003);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         idle(1);
         if (an == 4'hB && !got) begin
            got = 1'b1;
            chk("raw_digit2", 32'(BCDData), 32'h3F);
         end
      end
      chk("raw_digit2_seen", 32'(got), 32'h1);
      // disable while digit 2 is lit, then restart from digit 0
      wr(BASE + 4, 32'h0000_0001);
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         idle(1);
         got = an == 4'hB;
      end
      chk("reach_digit2", 32'(got), 32'h1);
      wr(BASE + 4, 32'h0);
      idle(1);
      chk("en_clear_blank", 32'(an), 32'hF);
      wr(BASE + 4, 32'h0000_0001);
      idle(1);
      chk("restart_digit0", 32'(an), 32'hE);
      idle(5);
      // asynchronous reset mid-scan
      #2 reset = 1'b0;
      #1;
      chk("async_an", 32'(an), 32'hF);
      chk("async_seg", 32'(BCDData), 32'hFF);
      m_reset();
      @(negedge clk);
      chk("async_hold_an", 32'(an), 32'hF);
      reset = 1'b1;
      idle(4);
      // randomized bus traffic against the model
      for (int k = 0; k < 400; k++) begin
         w = ($urandom % 3) == 0;
         r = $urandom % 2;
         a = ($urandom % 8 == 0) ? BASE - 32'(4 * (1 + $urandom % 4))
                                 : BASE + 32'(4 * ($urandom % 8)) + 32'($urandom % 4);
         d = $urandom;
         if (hit_off(a) == 4) d[0] = ($urandom % 4) != 0;
         step(w, r, a, d, r ? m_read(a) : 32'h0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
